branch_history_table: RTL

Direct-mapped table of 2-bit branch counters, indexed by PC, that sits directly upstream of the 2-bit saturating predictor FSM (FSM_2bit) in the RISC-V pipeline. Fetch looks up the stored counter for a branch PC. Execute returns the resolved outcome; the FSM computes the next counter value, which the table writes back. The registered lookup output is the `state_old` operand the FSM consumes.

---
 rtl/riscv_bp_pkg.sv | 22 ++
 rtl/bht_storage.sv | 35 +++
 rtl/branch_history_table.sv | 83 ++++++++
 3 files changed

// File: rtl/riscv_bp_pkg.sv
// Shared branch-predictor types: 2-bit counter encodings and the PC-to-index rule.
// Used by branch_history_table, bht_storage and FSM_2bit.
package riscv_bp_pkg;

  typedef logic [1:0] bp_state_t;

  localparam bp_state_t BP_STRONG_NT = 2'b00;
  localparam bp_state_t BP_WEAK_NT   = 2'b01;
  localparam bp_state_t BP_WEAK_T    = 2'b10;
  localparam bp_state_t BP_STRONG_T  = 2'b11;

  // Word-aligned PC: drop pc[1:0], keep the next index_w bits.
  function automatic logic [31:0] bht_idx(
    input logic [63:0] pc,
    input int unsigned index_w
  );
    logic [63:0] mask;
    mask = (64'd1 << index_w) - 64'd1;
    return 32'((pc >> 2) & mask);
  endfunction

endpackage

// File: rtl/bht_storage.sv
// Counter array for the branch history table.
// One async-read port, one sync-write port, async reset to RESET_STATE.
import riscv_bp_pkg::*;

module bht_storage #(
  parameter int        INDEX_W     = 6,
  parameter bp_state_t RESET_STATE = BP_WEAK_NT
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [INDEX_W-1:0] raddr_i,
  output bp_state_t          rdata_o,
  input  logic               we_i,
  input  logic [INDEX_W-1:0] waddr_i,
  input  bp_state_t          wdata_i
);

  localparam int DEPTH = 1 << INDEX_W;

  bp_state_t mem_q [DEPTH];

  // Counter flops: reset all entries, otherwise take the write port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RESET_STATE;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/branch_history_table.sv
// Direct-mapped 2-bit counter table feeding FSM_2bit's state_old.
// Define BHT_BYPASS_EN to forward a same-index update into the lookup.
import riscv_bp_pkg::*;

module branch_history_table #(
  parameter int        PC_W        = 32,
  parameter int        INDEX_W     = 6,
  parameter bp_state_t RESET_STATE = 2'b01
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lookup_valid,
  input  logic            lookup_stall,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            pred_valid,
  output bp_state_t       pred_state,
  output logic            pred_taken,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  bp_state_t       upd_state
);

  logic [INDEX_W-1:0] lk_idx;
  logic [INDEX_W-1:0] upd_idx;
  bp_state_t          rd_state;
  bp_state_t          lk_state;
  logic               fwd;

  logic      valid_q, valid_d;
  bp_state_t state_q, state_d;

  assign lk_idx  = INDEX_W'(bht_idx(64'(lookup_pc), unsigned'(INDEX_W)));
  assign upd_idx = INDEX_W'(bht_idx(64'(upd_pc), unsigned'(INDEX_W)));

  bht_storage #(
    .INDEX_W     (INDEX_W),
    .RESET_STATE (RESET_STATE)
  ) u_storage (
    .clk_i   (clk),
    .rst_ni  (rst),
    .raddr_i (lk_idx),
    .rdata_o (rd_state),
    .we_i    (upd_valid),
    .waddr_i (upd_idx),
    .wdata_i (upd_state)
  );

`ifdef BHT_BYPASS_EN
  assign fwd = upd_valid && (upd_idx == lk_idx);
`else
  assign fwd = 1'b0;
`endif

  assign lk_state = fwd ? upd_state : rd_state;

  // Next lookup outputs: stall freezes, idle cycles keep the last state.
  always_comb begin
    valid_d = valid_q;
    state_d = state_q;
    if (!lookup_stall) begin
      valid_d = lookup_valid;
      if (lookup_valid) begin
        state_d = lk_state;
      end
    end
  end

  // Lookup output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      state_q <= RESET_STATE;
    end else begin
      valid_q <= valid_d;
      state_q <= state_d;
    end
  end

  assign pred_valid = valid_q;
  assign pred_state = state_q;
  assign pred_taken = state_q[1];

endmodule
